// File: rtl/rbz_vec_pkg.sv
// rbz_vec_pkg: view-vector frame constants, reset defaults and field helper
package rbz_vec_pkg;
  localparam int FIELD_W = 16;
  localparam int NUM_FIELDS = 6;
  localparam int FRAME_BITS = FIELD_W * NUM_FIELDS;
  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam int F_PX = 0;
  localparam int F_PY = 1;
  localparam int F_FX = 2;
  localparam int F_FY = 3;
  localparam int F_VX = 4;
  localparam int F_VY = 5;
  localparam logic [FIELD_W-1:0] RST_PX = 16'h0C00;
  localparam logic [FIELD_W-1:0] RST_PY = 16'h0C00;
  localparam logic [FIELD_W-1:0] RST_FX = 16'h0000;
  localparam logic [FIELD_W-1:0] RST_FY = 16'hC000;
  localparam logic [FIELD_W-1:0] RST_VX = 16'h2000;
  localparam logic [FIELD_W-1:0] RST_VY = 16'h0000;
  localparam logic [FRAME_BITS-1:0] RST_FRAME = {RST_PX, RST_PY, RST_FX, RST_FY, RST_VX, RST_VY};
  typedef enum logic {S_IDLE, S_RX} state_t;
  function automatic logic [FIELD_W-1:0] field(input logic [FRAME_BITS-1:0] f, input int i);
    return f[FRAME_BITS-1-FIELD_W*i -: FIELD_W];
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-FF synchroniser plus registered stage giving rise/fall pulses
module spi_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [2:0] s;
  always_ff @(posedge clk) s <= reset ? 3'b000 : {s[1:0], d};
  assign q = s[1];
  assign rise = s[1] & ~s[2];
  assign fall = ~s[1] & s[2];
endmodule

// File: rtl/vec_spi_slave.sv
// vec_spi_slave: SPI receiver for view vectors, committed to outputs only in vblank
module vec_spi_slave
  import rbz_vec_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_ss_n,
  input  logic               i_sclk,
  input  logic               i_mosi,
  input  logic               i_vblank,
  output logic [FIELD_W-1:0] o_player_x,
  output logic [FIELD_W-1:0] o_player_y,
  output logic [FIELD_W-1:0] o_facing_x,
  output logic [FIELD_W-1:0] o_facing_y,
  output logic [FIELD_W-1:0] o_vplane_x,
  output logic [FIELD_W-1:0] o_vplane_y,
  output logic               o_pending,
  output logic               o_commit,
  output logic               o_frame_err
);
  logic ss_n, ss_rise, ss_fall, sclk_q, sclk_rise, sclk_fall, mosi;
  state_t state, state_nx;
  logic armed, pending, commit_q, err_q;
  logic frame_end, frame_ok, do_shift, do_commit, do_arm;
  logic [CNT_W-1:0] cnt;
  logic [FRAME_BITS-1:0] shift, pend_buf, out_q;
  spi_sync_edge u_ss (.clk(clk), .reset(reset), .d(i_ss_n), .q(ss_n), .rise(ss_rise), .fall(ss_fall));
  spi_sync_edge u_sclk (.clk(clk), .reset(reset), .d(i_sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge u_mosi (.clk(clk), .reset(reset), .d(i_mosi), .q(mosi), .rise(), .fall());
  always_comb begin
    do_arm = state == S_IDLE && ss_fall;
    frame_end = state == S_RX && ss_rise;
    state_nx = do_arm ? S_RX : frame_end ? S_IDLE : state;
    frame_ok = frame_end && cnt == CNT_W'(FRAME_BITS);
    do_shift = sclk_rise && !ss_n && armed && cnt != CNT_W'(FRAME_BITS + 1);
    do_commit = i_vblank && pending;
  end
  always_ff @(posedge clk) state <= reset ? S_IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (reset) begin
      armed <= 1'b0;
      pending <= 1'b0;
      cnt <= '0;
      shift <= '0;
      pend_buf <= '0;
      out_q <= RST_FRAME;
      commit_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      commit_q <= do_commit;
      err_q <= frame_end && !frame_ok;
      if (do_arm) begin
        cnt <= '0;
        armed <= 1'b1;
      end else if (do_shift) begin
        shift <= {shift[FRAME_BITS-2:0], mosi};
        cnt <= cnt + 1'b1;
      end
      if (do_commit) out_q <= pend_buf;
      if (frame_ok) pend_buf <= shift;
      pending <= frame_ok || (pending && !do_commit);
    end
  end
  assign o_player_x = field(out_q, F_PX);
  assign o_player_y = field(out_q, F_PY);
  assign o_facing_x = field(out_q, F_FX);
  assign o_facing_y = field(out_q, F_FY);
  assign o_vplane_x = field(out_q, F_VX);
  assign o_vplane_y = field(out_q, F_VY);
  assign o_pending = pending;
  assign o_commit = commit_q;
  assign o_frame_err = err_q;
endmodule

// File: tb/tb_vec_spi_slave.sv
// tb_vec_spi_slave: directed table-driven bench for vec_spi_slave
module tb_vec_spi_slave;
  logic clk = 0, reset = 1, ss_n = 1, sclk = 0, mosi = 0, vblank = 0;
  logic [15:0] px, py, fx, fy, vx, vy;
  logic pending, commit, frame_err;
  wire [95:0] outv = {px, py, fx, fy, vx, vy};
  int pass = 0, total = 0, err_cnt = 0, com_cnt = 0;
  localparam logic [95:0] RST_V = 96'h0C00_0C00_0000_C000_2000_0000;
  localparam logic [95:0] F1 = 96'h0400_0800_4000_0000_0000_2000;
  localparam logic [95:0] FA = 96'h1111_2222_3333_4444_5555_6666;
  localparam logic [95:0] FB = 96'hFEDC_BA98_7654_3210_8000_7FFF;
  localparam logic [95:0] FC = 96'h0123_4567_89AB_CDEF_0F0F_F0F0;
  localparam logic [95:0] FD = 96'hA5A5_5A5A_0001_FFFF_1234_8765;
  localparam logic [95:0] FE = 96'h7FFF_8001_C000_4000_E000_1FFF;
  typedef struct {
    logic [95:0] frame;
    int nbits;
    bit vblank;
    bit exp_pend;
    int exp_err;
    logic [95:0] exp_out;
  } vec_t;
  vec_t tbl[5];
  logic [95:0] prev;
  int e0, c0;
  vec_spi_slave dut (
    .clk(clk), .reset(reset), .i_ss_n(ss_n), .i_sclk(sclk), .i_mosi(mosi), .i_vblank(vblank),
    .o_player_x(px), .o_player_y(py), .o_facing_x(fx), .o_facing_y(fy),
    .o_vplane_x(vx), .o_vplane_y(vy), .o_pending(pending), .o_commit(commit),
    .o_frame_err(frame_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (frame_err) err_cnt++;
    if (commit) com_cnt++;
  end
  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass++;
  endtask
  task automatic spi_send(input logic [95:0] f, input int n, input bit lower);
    if (lower) begin
      @(negedge clk) ss_n = 0;
      repeat (8) @(negedge clk);
    end
    for (int i = 0; i < n; i++) begin
      mosi = i < 96 ? f[95-i] : 1'b0;
      repeat (4) @(negedge clk);
      sclk = 1;
      repeat (4) @(negedge clk);
      sclk = 0;
    end
    repeat (4) @(negedge clk);
  endtask
  task automatic spi_end();
    @(negedge clk) ss_n = 1;
    repeat (10) @(negedge clk);
  endtask
  task automatic do_vblank(input logic [95:0] exp_out, input bit exp_commit, input string tag);
    c0 = com_cnt;
    @(negedge clk) vblank = 1;
    @(posedge clk);
    #1;
    chk({tag, "_commit"}, 96'(commit), 96'(exp_commit));
    chk({tag, "_out"}, outv, exp_out);
    chk({tag, "_pend_clr"}, 96'(pending), 96'(0));
    repeat (4) @(negedge clk);
    vblank = 0;
    chk({tag, "_ncommit"}, 96'(com_cnt - c0), 96'(exp_commit));
  endtask
  initial begin
    tbl[0] = '{F1, 96, 1, 1, 0, F1};
    tbl[1] = '{FA, 95, 1, 0, 1, F1};
    tbl[2] = '{FB, 97, 1, 0, 1, F1};
    tbl[3] = '{FA, 96, 0, 1, 0, F1};
    tbl[4] = '{FB, 96, 1, 1, 0, FB};
    repeat (4) @(negedge clk);
    reset = 0;
    repeat (6) @(negedge clk);
    chk("rst_out", outv, RST_V);
    chk("rst_pend", 96'(pending), 96'(0));
    chk("rst_pulses", 96'(err_cnt + com_cnt), 96'(0));
    prev = RST_V;
    for (int i = 0; i < 5; i++) begin
      e0 = err_cnt;
      spi_send(tbl[i].frame, tbl[i].nbits, 1);
      spi_end();
      chk($sformatf("v%0d_pend", i), 96'(pending), 96'(tbl[i].exp_pend));
      chk($sformatf("v%0d_err", i), 96'(err_cnt - e0), 96'(tbl[i].exp_err));
      chk($sformatf("v%0d_hold", i), outv, prev);
      if (tbl[i].vblank) do_vblank(tbl[i].exp_out, tbl[i].exp_pend, $sformatf("v%0d", i));
      prev = tbl[i].exp_out;
    end
    // collision: FC completes in the exact cycle FA commits
    spi_send(FA, 96, 1);
    spi_end();
    spi_send(FC, 96, 1);
    @(negedge clk) ss_n = 1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) vblank = 1;
    @(posedge clk);
    #1;
    chk("col_commit", 96'(commit), 96'(1));
    chk("col_out", outv, FA);
    chk("col_pend", 96'(pending), 96'(1));
    @(negedge clk) vblank = 0;
    repeat (8) @(negedge clk);
    do_vblank(FC, 1, "col_next");
    // SS_N low through reset release: frame ignored until a real fall
    @(negedge clk) begin reset = 1; ss_n = 0; end
    repeat (4) @(negedge clk);
    reset = 0;
    e0 = err_cnt;
    spi_send(FD, 96, 0);
    spi_end();
    chk("sslow_pend", 96'(pending), 96'(0));
    chk("sslow_err", 96'(err_cnt - e0), 96'(0));
    chk("sslow_out", outv, RST_V);
    spi_send(FE, 96, 1);
    spi_end();
    chk("sslow_next_pend", 96'(pending), 96'(1));
    do_vblank(FE, 1, "sslow_next");
    // reset 40 bits into a frame, with a frame already pending
    spi_send(FA, 96, 1);
    spi_end();
    e0 = err_cnt;
    spi_send(FB, 40, 1);
    @(negedge clk) begin reset = 1; ss_n = 1; end
    repeat (3) @(negedge clk);
    reset = 0;
    repeat (8) @(negedge clk);
    chk("mid_out", outv, RST_V);
    chk("mid_pend", 96'(pending), 96'(0));
    chk("mid_err", 96'(err_cnt - e0), 96'(0));
    spi_send(FD, 96, 1);
    spi_end();
    chk("mid_next_pend", 96'(pending), 96'(1));
    do_vblank(FD, 1, "mid_next");
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
